gcd_controller: RTL and testbench
=================================

// Module: gcd_controller
// PURPOSE
//  Sequencing FSM for gcd_datapath (subtract-and-compare GCD engine).
//  - Accepts an operand pair on a start pulse.
//  - Drives the datapath mux selects and load enables until eq_flag is seen,
//    then presents the result with a valid/ack handshake.
//  - A watchdog iteration counter traps non-terminating operand pairs
//    (one operand zero) and reports an error instead of hanging.
// PARAMETERS
//  MAX_ITER  15  Subtract steps allowed before watchdog error. 15 covers the 4-bit worst case: gcd(1,15) takes 14 steps.
//  ITER_W    4   Width of iter_count; must hold MAX_ITER.
// PORTS
//  clk          in   1       Single clock; everything is on the rising edge.
//  rst          in   1       Synchronous, active-high reset.
//  start        in   1       Request a new GCD. Sampled only in IDLE; ignored otherwise.
//  eq_flag      in   1       From datapath: a==b.
//  bigger       in   1       From datapath: a>b.
//  res_ack      in   1       Consumer accepts result or error.
//  rst_dp       out  1       Datapath register clear. Equals rst, combinational.
//  A_sel        out  1       0 = load operand A, 1 = load a-b.
//  B_sel        out  1       0 = load operand B, 1 = load b-a.
//  A_load       out  1       Load enable for datapath reg A.
//  B_load       out  1       Load enable for datapath reg B.
//  done         out  1       One-cycle pulse; datapath latches a into res on this edge.
//  busy         out  1       High in CALC, RESULT and ERROR.
//  result_valid out  1       res is valid. Held until res_ack.
//  err          out  1       Watchdog tripped. Held until res_ack.
//  iter_count   out  ITER_W  Subtract steps taken in the current or last operation.
// BEHAVIOUR
//  Reset values: state=IDLE, iter_count=0. All outputs 0 except rst_dp=1 while rst is high.
//  Control outputs are combinational from state and flags (Mealy in IDLE and CALC).
//  Status outputs busy, result_valid and err decode the state register.
//  IDLE
//   - start=1: A_load=B_load=1, A_sel=B_sel=0, iter_count<=0, next CALC.
//   - start=0: stay IDLE.
//  CALC (flags reflect the registered a,b)
//   - eq_flag=1: done=1, next RESULT. Checked first.
//   - eq_flag=0, iter_count==MAX_ITER: no loads, next ERROR.
//   - bigger=1: A_sel=1, A_load=1, iter_count++, stay CALC.
//   - otherwise: B_sel=1, B_load=1, iter_count++, stay CALC.
//   - A_load and B_load are never both high in CALC.
//  RESULT: result_valid=1, res stable.
//   - res_ack=1: next IDLE; result_valid is low the following cycle.
//  ERROR: err=1.
//   - res_ack=1: next IDLE.
//   - done is never asserted on this path; res keeps its previous value.
//  Latency: start at cycle 0 -> result_valid at cycle 2+N, where N = iter_count.
//  Boundary conditions:
//   - start held high across an operation: one new operation only on re-entering IDLE.
//   - start in the same cycle as res_ack: ignored; it must be presented in IDLE.
//   - rst mid-operation: state=IDLE next edge, datapath cleared via rst_dp,
//     no done pulse, pending result discarded.
//   - A=B=0: eq in the first CALC cycle -> result 0, valid, no error.
//   - Exactly one of A,B zero: never equal -> err after MAX_ITER steps.
//   - iter_count saturates at MAX_ITER and holds its value after completion until the next start.
// STRUCTURE
//  gcd_pkg: state enum {IDLE, CALC, RESULT, ERROR} (2-bit), DATA_W=4, default MAX_ITER.
//  Sub-module gcd_iter_counter: clear, increment, terminal-count compare against MAX_ITER.
//  Top level: state register, next-state/output logic, counter instance.
// TESTING (with gcd_datapath attached)
//  1. A=12, B=8, start@c0 -> A_load@c1, B_load@c2, done@c3, result_valid@c4, res=4, iter_count=2.
//  2. A=5, B=5 -> done@c1, result_valid@c2, res=5, iter_count=0.
//  3. A=1, B=15 -> 14 B_load steps, res=1, iter_count=14, err=0.
//  4. A=0, B=5 -> err=1 after 15 steps, done never pulses; res_ack -> IDLE.
//  5. rst at c2 of case 1 -> IDLE next cycle, all outputs 0, then a new start gives a correct result.
//  6. result_valid held 5 cycles without ack while start toggles -> res stable, no new loads; ack -> IDLE.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtract-and-compare GCD engine.
package gcd_pkg;

  localparam int DATA_W       = 4;
  localparam int MAX_ITER_DEF = 15;
  localparam int ITER_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2,
    ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_iter_counter.sv
// Watchdog step counter: cleared on a new operation, saturating at MAX_ITER.
module gcd_iter_counter
  import gcd_pkg::*;
#(
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              tc
);

  // Step counter register; holds its value after completion until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + ITER_W'(1);
    end else begin
      count <= count;
    end
  end

  // Terminal count against the watchdog limit.
  always_comb begin
    tc = (count == ITER_W'(MAX_ITER));
  end

endmodule

// File: rtl/gcd_controller.sv
// Sequencing FSM for the GCD datapath: load, subtract until equal, then
// present the result (or a watchdog error) with a valid/ack handshake.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int ITER_W   = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              eq_flag,
  input  logic              bigger,
  input  logic              res_ack,
  output logic              rst_dp,
  output logic              A_sel,
  output logic              B_sel,
  output logic              A_load,
  output logic              B_load,
  output logic              done,
  output logic              busy,
  output logic              result_valid,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  state_t state, state_next;
  logic   cnt_clear, cnt_inc, cnt_tc;

  gcd_iter_counter #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .count(iter_count),
    .tc   (cnt_tc)
  );

  assign rst_dp = rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; everything is forced low while in reset.
  always_comb begin
    state_next   = state;
    A_sel        = 1'b0;
    B_sel        = 1'b0;
    A_load       = 1'b0;
    B_load       = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    err          = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    if (rst) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            A_load     = 1'b1;
            B_load     = 1'b1;
            cnt_clear  = 1'b1;
            state_next = CALC;
          end else begin
            state_next = IDLE;
          end
        end
        CALC: begin
          busy = 1'b1;
          // Equality wins over the watchdog so a final-step match still completes.
          if (eq_flag) begin
            done       = 1'b1;
            state_next = RESULT;
          end else if (cnt_tc) begin
            state_next = ERROR;
          end else if (bigger) begin
            A_sel   = 1'b1;
            A_load  = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            B_sel   = 1'b1;
            B_load  = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        RESULT: begin
          busy         = 1'b1;
          result_valid = 1'b1;
          if (res_ack) begin
            state_next = IDLE;
          end else begin
            state_next = RESULT;
          end
        end
        ERROR: begin
          busy = 1'b1;
          err  = 1'b1;
          if (res_ack) begin
            state_next = IDLE;
          end else begin
            state_next = ERROR;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a behavioural subtract-and-compare datapath.
module tb_gcd_controller;
  import gcd_pkg::*;

  logic clk = 1'b0;
  logic rst, start, res_ack;
  logic eq_flag, bigger;
  logic rst_dp, A_sel, B_sel, A_load, B_load, done, busy, result_valid, err;
  logic [3:0] iter_count;

  logic [DATA_W-1:0] a_in, b_in, a, b, res;

  int checks = 0;
  int failures = 0;
  int cnt;
  int dcnt;
  int cyc;

  gcd_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .eq_flag     (eq_flag),
    .bigger      (bigger),
    .res_ack     (res_ack),
    .rst_dp      (rst_dp),
    .A_sel       (A_sel),
    .B_sel       (B_sel),
    .A_load      (A_load),
    .B_load      (B_load),
    .done        (done),
    .busy        (busy),
    .result_valid(result_valid),
    .err         (err),
    .iter_count  (iter_count)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the controller.
  always @(posedge clk) begin
    if (rst_dp) begin
      a   <= '0;
      b   <= '0;
      res <= '0;
    end else begin
      if (A_load) a <= A_sel ? (a - b) : a_in;
      if (B_load) b <= B_sel ? (b - a) : b_in;
      if (done) res <= a;
    end
  end

  assign eq_flag = (a == b);
  assign bigger  = (a > b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ack = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("rst_dp_in_reset", rst_dp, 1);
    chk("busy_in_reset", busy, 0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("reset_iter", iter_count, 0);
    chk("reset_status", {busy, result_valid, err, done}, 0);
    chk("reset_loads", {A_load, B_load}, 0);

    // Case 1: gcd(12,8)
    a_in = 4'd12; b_in = 4'd8; start = 1'b1; #1;
    chk("c1_load_c0", {A_load, B_load, A_sel, B_sel}, 4'b1100);
    tick(); start = 1'b0; #1;
    chk("c1_c1_Astep", {A_load, B_load, A_sel, B_sel, busy}, 5'b10101);
    tick();
    chk("c1_c2_Bstep", {A_load, B_load, A_sel, B_sel}, 4'b0101);
    tick();
    chk("c1_c3_done", done, 1);
    tick();
    chk("c1_c4_valid", result_valid, 1);
    chk("c1_res", res, 4);
    chk("c1_iter", iter_count, 2);
    res_ack = 1'b1; tick(); res_ack = 1'b0; #1;
    chk("c1_valid_drop", {result_valid, busy}, 0);
    chk("c1_iter_hold", iter_count, 2);

    // Case 2: gcd(5,5), start held high across the operation
    a_in = 4'd5; b_in = 4'd5; start = 1'b1; #1;
    tick();
    chk("c2_done_c1", done, 1);
    chk("c2_no_load", {A_load, B_load}, 0);
    tick();
    chk("c2_valid_c2", result_valid, 1);
    chk("c2_res", res, 5);
    chk("c2_iter", iter_count, 0);
    start = 1'b0; res_ack = 1'b1; tick(); res_ack = 1'b0; #1;
    chk("c2_idle", busy, 0);

    // Case 3: gcd(1,15), worst case
    a_in = 4'd1; b_in = 4'd15; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    cnt = 0; dcnt = 0; cyc = 1;
    while (!result_valid && !err && cyc < 40) begin
      if (B_load) cnt++;
      if (done) dcnt++;
      tick(); cyc++;
    end
    chk("c3_latency", cyc, 16);
    chk("c3_bsteps", cnt, 14);
    chk("c3_done_cnt", dcnt, 1);
    chk("c3_res", res, 1);
    chk("c3_iter", iter_count, 14);
    chk("c3_err", err, 0);
    res_ack = 1'b1; tick(); res_ack = 1'b0; #1;

    // Case 4: A=0 never converges, watchdog error
    a_in = 4'd0; b_in = 4'd5; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    dcnt = 0; cyc = 1;
    while (!err && !result_valid && cyc < 40) begin
      if (done) dcnt++;
      tick(); cyc++;
    end
    chk("c4_err", err, 1);
    chk("c4_err_cycle", cyc, 17);
    chk("c4_no_done", dcnt, 0);
    chk("c4_iter_sat", iter_count, 15);
    chk("c4_res_kept", res, 1);
    chk("c4_no_valid", result_valid, 0);
    res_ack = 1'b1; tick(); res_ack = 1'b0; #1;
    chk("c4_idle", {busy, err}, 0);

    // Case 5: reset mid-operation, then recovery with gcd(9,6)
    a_in = 4'd12; b_in = 4'd8; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    tick();
    rst = 1'b1; #1;
    chk("c5_rst_dp", rst_dp, 1);
    chk("c5_outs_in_rst", {A_load, B_load, A_sel, B_sel, done, busy, result_valid, err}, 0);
    tick(); rst = 1'b0; #1;
    chk("c5_outs_after", {rst_dp, A_load, B_load, done, busy, result_valid, err}, 0);
    chk("c5_iter", iter_count, 0);
    chk("c5_dp_cleared", res, 0);
    a_in = 4'd9; b_in = 4'd6; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    tick(); tick(); tick();
    chk("c5_valid", result_valid, 1);
    chk("c5_res", res, 3);
    chk("c5_iter2", iter_count, 2);
    res_ack = 1'b1; tick(); res_ack = 1'b0; #1;

    // Case 6: result held without ack while start toggles
    a_in = 4'd6; b_in = 4'd4; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    tick(); tick(); tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      start = i[0]; a_in = 4'd7; b_in = 4'd3; #1;
      if (!result_valid || res != 4'd2 || A_load || B_load) cnt++;
      tick();
    end
    chk("c6_hold_bad_cycles", cnt, 0);
    chk("c6_res", res, 2);
    start = 1'b1; res_ack = 1'b1; #1;
    chk("c6_ack_no_load", {A_load, B_load}, 0);
    tick(); start = 1'b0; res_ack = 1'b0; #1;
    chk("c6_idle", {busy, result_valid, A_load}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
